// File: rtl/demux_1_16_loader_if.sv
// Write-side handshake bundle for the 1-to-16 lane loader.
// The producer uses the master modport, the loader uses the slave modport.
interface demux_1_16_loader_if #(
    parameter int SIZE = 16
);
    logic            in_valid;
    logic [SIZE-1:0] in_data;
    logic [3:0]      in_sel;
    logic            in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_sel,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_sel,
        output in_ready
    );
endinterface

// File: rtl/demux_1_16_loader.sv
// Sequential 1-to-16 distributor feeding the 16 data inputs of the 16:1 mux.
// Words arrive over a valid/ready handshake. In IDLE the target lane comes
// from in_sel. In SWEEP it comes from an internal counter that fills lanes
// 0..15 in order. A one-cycle DONE state reports the end of a sweep.
module demux_1_16_loader #(
    parameter int SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    demux_1_16_loader_if.slave   in_port,
    output logic [16*SIZE-1:0]   out_bus,
    output logic [15:0]          out_strobe,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [3:0]      cnt;
    logic            ready;
    logic            accept;
    logic            wr_en;
    logic [3:0]      wr_idx;
    logic [SIZE-1:0] lanes [16];

    // State register; reset forces IDLE at once, even in the middle of a sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; in SWEEP, abort wins over a final accept.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SWEEP;
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (accept && (cnt == 4'd15)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State-decoded outputs; in_ready has no path from in_valid.
    always_comb begin
        ready = 1'b1;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
            end
            SWEEP: begin
                ready = 1'b1;
                busy  = 1'b1;
            end
            DONE: begin
                ready = 1'b0;
                busy  = 1'b1;
                done  = 1'b1;
            end
            default: begin
                ready = 1'b1;
            end
        endcase
    end

    assign in_port.in_ready = ready;
    assign accept           = in_port.in_valid && ready;

    // Pick the lane to write: explicit select in IDLE, sweep counter in SWEEP.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = in_port.in_sel;
        case (state)
            IDLE: begin
                wr_en = accept;
            end
            SWEEP: begin
                wr_en  = accept && !abort;
                wr_idx = cnt;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // Sweep counter: cleared by start, advanced per sweep write, held on stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if ((state == IDLE) && start) begin
            cnt <= 4'd0;
        end else if ((state == SWEEP) && wr_en) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Lane storage; a lane keeps its value until rewritten or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                lanes[k] <= '0;
            end
        end else if (wr_en) begin
            lanes[wr_idx] <= in_port.in_data;
        end
    end

    // One-hot strobe marking the lane written at the previous edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_strobe <= '0;
        end else if (wr_en) begin
            out_strobe <= 16'b1 << wr_idx;
        end else begin
            out_strobe <= '0;
        end
    end

    // Lane k occupies slice k of the packed bus, matching mux select k.
    for (genvar k = 0; k < 16; k++) begin : g_bus
        assign out_bus[k*SIZE +: SIZE] = lanes[k];
    end

endmodule

// File: tb/tb_demux_1_16_loader.sv
// Scoreboard bench for demux_1_16_loader: the driver pushes the expected
// strobe/bus/done snapshot for every write it issues, and a monitor pops and
// compares whenever the DUT shows a strobe or done pulse.
module tb_demux_1_16_loader;

    localparam int SIZE = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                abort;
    logic [16*SIZE-1:0]  out_bus;
    logic [15:0]         out_strobe;
    logic                busy;
    logic                done;

    demux_1_16_loader_if #(.SIZE(SIZE)) bus_if ();

    demux_1_16_loader #(.SIZE(SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .in_port    (bus_if.slave),
        .out_bus    (out_bus),
        .out_strobe (out_strobe),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]        strobe;
        logic [16*SIZE-1:0] bus;
        logic               done;
        logic               busy;
    } exp_t;

    exp_t            exp_q[$];
    logic [SIZE-1:0] model_lanes [16];
    int              tests_run    = 0;
    int              tests_failed = 0;
    int              done_seen    = 0;

    function automatic logic [16*SIZE-1:0] model_bus();
        logic [16*SIZE-1:0] b;
        for (int k = 0; k < 16; k++) begin
            b[k*SIZE +: SIZE] = model_lanes[k];
        end
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs; when a write is expected, record its outcome.
    task automatic applyStimulus(input logic v, input logic [SIZE-1:0] d,
                                 input logic [3:0] sel, input logic st,
                                 input logic ab, input int exp_lane,
                                 input logic exp_done, input logic exp_busy);
        exp_t e;
        @(negedge clk);
        bus_if.in_valid = v;
        bus_if.in_data  = d;
        bus_if.in_sel   = sel;
        start           = st;
        abort           = ab;
        @(posedge clk);
        if (exp_lane >= 0) begin
            model_lanes[exp_lane] = d;
            e.strobe = 16'b1 << exp_lane;
            e.bus    = model_bus();
            e.done   = exp_done;
            e.busy   = exp_busy;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle_cycle();
        applyStimulus(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, -1, 1'b0, 1'b0);
    endtask

    // start, then words base+k; optional two-cycle gap after the 7th word.
    task automatic run_sweep(input logic [SIZE-1:0] base, input logic gap);
        applyStimulus(1'b0, 16'h0000, 4'd0, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, base + 16'(k), 4'(15 - k), 1'b0, 1'b0, k,
                          (k == 15), 1'b1);
            if (gap && (k == 6)) begin
                idle_cycle();
                idle_cycle();
            end
        end
    endtask

    // Monitor: every strobe or done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && ((out_strobe != 16'h0) || (done === 1'b1))) begin
            if (done === 1'b1) done_seen++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_output", 256'({out_strobe, done}), 256'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("strobe",   256'(out_strobe),      256'(e.strobe));
                checkOutput("bus",      256'(out_bus),         256'(e.bus));
                checkOutput("done",     256'(done),            256'(e.done));
                checkOutput("busy",     256'(busy),            256'(e.busy));
                checkOutput("in_ready", 256'(bus_if.in_ready), 256'(!e.done));
            end
        end
    end

    initial begin
        int done_before;
        for (int k = 0; k < 16; k++) model_lanes[k] = '0;
        rst             = 1'b1;
        start           = 1'b0;
        abort           = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;
        bus_if.in_sel   = '0;

        // Reset state
        #1;
        checkOutput("rst_bus",    256'(out_bus),         256'(0));
        checkOutput("rst_strobe", 256'(out_strobe),      256'(0));
        checkOutput("rst_busy",   256'(busy),            256'(0));
        checkOutput("rst_done",   256'(done),            256'(0));
        checkOutput("rst_ready",  256'(bus_if.in_ready), 256'(1));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Direct mode: lane 0 then lane 15
        applyStimulus(1'b1, 16'hAAAA, 4'd0,  1'b0, 1'b0, 0,  1'b0, 1'b0);
        applyStimulus(1'b1, 16'h5555, 4'd15, 1'b0, 1'b0, 15, 1'b0, 1'b0);
        idle_cycle();

        // Same-lane overwrite on back-to-back cycles
        applyStimulus(1'b1, 16'h0001, 4'd7, 1'b0, 1'b0, 7, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0002, 4'd7, 1'b0, 1'b0, 7, 1'b0, 1'b0);
        idle_cycle();
        #1;
        checkOutput("lane7_last", 256'(out_bus[127:112]), 256'(16'h0002));

        // Full sweep with a stall; in_valid during DONE must be ignored
        done_before = done_seen;
        run_sweep(16'h0100, 1'b1);
        applyStimulus(1'b1, 16'hBEEF, 4'd2, 1'b0, 1'b0, -1, 1'b0, 1'b1);
        idle_cycle();
        idle_cycle();
        checkOutput("sweep_done_count", 256'(done_seen - done_before), 256'(1));

        // Abort after four accepts; the abort-cycle word is dropped
        done_before = done_seen;
        applyStimulus(1'b0, 16'h0000, 4'd0, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 16'h0011 + 16'(k), 4'd9, 1'b0, 1'b0, k, 1'b0, 1'b1);
        end
        applyStimulus(1'b1, 16'hFFFF, 4'd9, 1'b0, 1'b1, -1, 1'b0, 1'b1);
        #1;
        checkOutput("abort_busy",  256'(busy),            256'(0));
        checkOutput("abort_ready", 256'(bus_if.in_ready), 256'(1));
        checkOutput("abort_lane4", 256'(out_bus[79:64]),  256'(model_lanes[4]));
        checkOutput("abort_lanes", 256'(out_bus),         256'(model_bus()));
        idle_cycle();
        idle_cycle();
        checkOutput("abort_no_done", 256'(done_seen - done_before), 256'(0));

        // Back-to-back sweeps; start during DONE is ignored
        done_before = done_seen;
        run_sweep(16'h0200, 1'b0);
        applyStimulus(1'b1, 16'hDEAD, 4'd9, 1'b1, 1'b0, -1, 1'b0, 1'b1);
        #1;
        checkOutput("done_start_ignored", 256'(busy), 256'(0));
        run_sweep(16'h0300, 1'b0);
        idle_cycle();
        idle_cycle();
        checkOutput("b2b_done_count", 256'(done_seen - done_before), 256'(2));
        checkOutput("b2b_bus", 256'(out_bus), 256'(model_bus()));

        // Asynchronous reset after five sweep accepts
        applyStimulus(1'b0, 16'h0000, 4'd0, 1'b1, 1'b0, -1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 16'h0400 + 16'(k), 4'd0, 1'b0, 1'b0, k, 1'b0, 1'b1);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 16; k++) model_lanes[k] = '0;
        checkOutput("mid_rst_bus",    256'(out_bus),         256'(0));
        checkOutput("mid_rst_strobe", 256'(out_strobe),      256'(0));
        checkOutput("mid_rst_busy",   256'(busy),            256'(0));
        checkOutput("mid_rst_done",   256'(done),            256'(0));
        checkOutput("mid_rst_ready",  256'(bus_if.in_ready), 256'(1));
        bus_if.in_valid = 1'b0;
        start           = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 16'h1234, 4'd3, 1'b0, 1'b0, 3, 1'b0, 1'b0);
        idle_cycle();
        #1;
        checkOutput("post_rst_lane3", 256'(out_bus[63:48]), 256'(16'h1234));

        idle_cycle();
        idle_cycle();
        checkOutput("queue_empty", 256'(exp_q.size()), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/demux_1_16_loader.md
# demux_1_16_loader

Sequential 1-to-16 distributor that is the write-side counterpart of the 16:1 selection path in the ODE accelerator. It accepts a stream of SIZE-bit words over a valid/ready handshake and stores each word into one of 16 lane registers. The target lane comes from an explicit select in direct mode or from an internal counter in sweep mode. The 16 lane registers drive a packed bus that feeds the 16 data inputs of the downstream 16:1 mux.

## Interface
- SIZE, 16, width of each data word and lane register

- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  in IDLE, begins a 16-word sweep; ignored in other states
- abort  input  1  synchronous; in SWEEP, returns to IDLE without done; ignored elsewhere
- in_valid  input  1  in_data (and in_sel in direct mode) is valid
- in_data  input  SIZE  word to store
- in_sel  input  4  target lane in direct mode; ignored in SWEEP
- in_ready  output  1  block can accept a word this cycle
- out_bus  output  16*SIZE  lane k on bits [(k+1)*SIZE-1 : k*SIZE]; lane 0 corresponds to mux select 0
- out_strobe  output  16  one-hot, one-cycle pulse marking the lane written at the previous edge
- busy  output  1  high in SWEEP and DONE
- done  output  1  one-cycle pulse when a sweep completes

## Operation
- **States:** IDLE, SWEEP, DONE. Internal 4-bit lane counter cnt.
- **Accept:** an accept occurs when in_valid && in_ready is high at a rising edge.
- **IDLE:**
  - in_ready=1.
  - On accept, lane[in_sel] <= in_data.
  - start=1 moves the FSM to SWEEP and sets cnt <= 0. In that same cycle, an accept still performs a direct write.
- **SWEEP:**
  - in_ready=1.
  - On accept, lane[cnt] <= in_data and cnt <= cnt+1.
  - Accept with cnt==15 moves the FSM to DONE, and cnt wraps to 0.
  - abort=1 moves the FSM to IDLE and takes priority over any accept in that cycle; no write occurs.
  - Lanes already written in the aborted sweep keep their values.
- **DONE:**
  - in_ready=0 and done=1, for exactly one cycle.
  - The FSM then returns to IDLE unconditionally.
  - start and in_valid are ignored in DONE.
- **out_strobe:**
  - Registered. Bit k=1 for the single cycle after an accept into lane k; otherwise all zero.
  - At most one bit is set at a time.
- **Lane registers:**
  - Each lane holds its value until it is written again or reset.
  - Writing the same lane on back-to-back cycles is legal; the last write wins.
- **Reset:**
  - State returns to IDLE, cnt=0, and all lane registers are 0.
  - Outputs take reset values immediately, even mid-sweep: out_bus=0, out_strobe=0, busy=0, done=0, in_ready=1.

## Timing
- Write latency is one cycle. A word accepted at edge N is visible on out_bus after edge N, together with its out_strobe bit.
- Throughput is one word per cycle in IDLE and SWEEP.
- A full sweep takes 16 accepts. done is high during the cycle after the 16th accept, which is the same cycle as out_strobe[15]. in_ready is low in that cycle.
- The earliest next start is the cycle after done, back in IDLE.
- busy rises in the cycle after start is sampled in IDLE and falls in the cycle after DONE.
- in_ready depends only on the state (no combinational path from in_valid). Stalls in SWEEP (in_valid=0) hold cnt.

## Test plan
- **Reset:** assert rst mid-sweep after 5 accepts -> out_bus=0, out_strobe=0, busy=0, done=0, in_ready=1 immediately. A subsequent direct write to lane 3 of 0x1234 -> out_bus[63:48]=0x1234.
- **Direct mode:** write in_sel=0 data 0xAAAA, then in_sel=15 data 0x5555 on consecutive cycles -> lane0=0xAAAA, lane15=0x5555, out_strobe=0x0001 then 0x8000, all other lanes 0.
- **Full sweep with gaps:**
  - Stimulus: start, then words 0x0100..0x010F with in_valid deasserted for 2 cycles after the 7th word.
  - Required response: lane k=0x0100+k, in_sel ignored, and done pulses once in the cycle after the 16th accept with in_ready=0.
- **Abort:** start, 4 accepts (0x11..0x14), then abort together with in_valid data 0xFFFF -> lanes 0..3 = 0x11..0x14, lane 4 unchanged, no done, state IDLE, busy=0 the next cycle.
- **Back-to-back:** two consecutive full sweeps with start re-asserted the cycle after done -> second sweep overwrites all lanes. start asserted during DONE is ignored. done pulses exactly twice.
- **Same-lane overwrite:** direct writes to lane 7 of 0x0001 then 0x0002 on consecutive cycles -> out_bus[127:112]=0x0002, out_strobe=0x0080 for two consecutive cycles.
